rd_engine: RTL

- AXI4 read-side benchmark engine for one HBM pseudo-channel; the companion to the write engine in the HBM benchmark.
- Issues a programmed sequence of AR bursts with strided, work-group-masked addresses and sinks all R beats.
- Reports total cycles (throughput mode) or summed per-request latency (latency mode) to the benchmark controller via lat_timer_sum / end_of_exec.

---
 rtl/hbm_bench_pkg.sv | 44 ++++
 rtl/hbm_addr_gen.sv | 47 ++++
 rtl/rd_engine.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/hbm_bench_pkg.sv
// Shared definitions for the HBM benchmark read/write engines.
// Holds the lt_params field layout, the engine state encoding, the fixed AXI
// attribute values and the AxSIZE helper.
package hbm_bench_pkg;

  // lt_params field layout
  localparam int unsigned WG_LSB       = 0;
  localparam int unsigned WG_W         = 32;
  localparam int unsigned STRIDE_LSB   = 32;
  localparam int unsigned STRIDE_W     = 32;
  localparam int unsigned NOPS_LSB     = 64;
  localparam int unsigned NOPS_W       = 64;
  localparam int unsigned BURST_LSB    = 128;
  localparam int unsigned BURST_W      = 32;
  localparam int unsigned INIT_LSB     = 160;
  localparam int unsigned LAT_MODE_BIT = 255;

  localparam int unsigned TIMER_W = 64;
  localparam int unsigned ERR_W   = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STARTED  = 3'd1,
    ST_TH_ADDR  = 3'd2,
    ST_TH_DATA  = 3'd3,
    ST_LAT_ADDR = 3'd4,
    ST_LAT_WAIT = 3'd5,
    ST_END      = 3'd6
  } eng_state_e;

  // Fixed AXI attributes: INCR bursts, normal access, unprivileged/non-secure data
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_LOCK       = 2'b00;
  localparam logic [3:0] AXI_CACHE      = 4'b0000;
  localparam logic [2:0] AXI_PROT       = 3'b010;
  localparam logic [3:0] AXI_QOS        = 4'b0000;
  localparam logic [3:0] AXI_REGION     = 4'b0000;

  // AxSIZE for a full-width beat; only 256 and 512 bit buses are supported
  function automatic logic [2:0] axsize_f(input int unsigned dw);
    return (dw == 512) ? 3'b110 : 3'b101;
  endfunction

endpackage

// File: rtl/hbm_addr_gen.sv
// Strided, work-group-masked address generator.
// Ports: clk, rst (sync, active-high), clear_i (zero the offset),
//        advance_i (add stride after an accepted request), init_addr_i,
//        stride_i, mask_i (work_group_size-1), addr_o (registered address).
// addr_o = init_addr_i + (offset & mask_i); the offset wraps silently.
module hbm_addr_gen
  import hbm_bench_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 33
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  advance_i,
  input  logic [ADDR_WIDTH-1:0] init_addr_i,
  input  logic [STRIDE_W-1:0]   stride_i,
  input  logic [ADDR_WIDTH-1:0] mask_i,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  logic [ADDR_WIDTH-1:0] offset_q, offset_d;
  logic [ADDR_WIDTH-1:0] addr_q;

  // Next offset: clear wins over advance
  always_comb begin
    offset_d = offset_q;
    if (clear_i) begin
      offset_d = '0;
    end else if (advance_i) begin
      offset_d = offset_q + ADDR_WIDTH'(stride_i);
    end
  end

  // Address is recomputed every cycle so a late mask update is picked up
  always_ff @(posedge clk) begin
    if (rst) begin
      offset_q <= '0;
      addr_q   <= '0;
    end else begin
      offset_q <= offset_d;
      addr_q   <= init_addr_i + (offset_d & mask_i);
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/rd_engine.sv
// AXI4 read benchmark engine for one HBM pseudo-channel.
// Ports: clk, rst (sync, active-high), start, lt_params (run parameters),
//        end_of_exec (one-cycle done pulse), lat_timer_sum (cycle result),
//        rd_err_cnt (R beats with RRESP != 0), m_axi_AR* (address channel),
//        m_axi_R* (data channel, always ready).
// Throughput mode issues all ARs back to back and times the whole run;
// latency mode keeps one AR outstanding and sums per-request latency.
module rd_engine
  import hbm_bench_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 33,
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned PARAMS_BITS = 256,
  parameter int unsigned ID_WIDTH    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PARAMS_BITS-1:0] lt_params,
  output logic                   end_of_exec,
  output logic [TIMER_W-1:0]     lat_timer_sum,
  output logic [ERR_W-1:0]       rd_err_cnt,
  output logic                   m_axi_ARVALID,
  input  logic                   m_axi_ARREADY,
  output logic [ADDR_WIDTH-1:0]  m_axi_ARADDR,
  output logic [ID_WIDTH-1:0]    m_axi_ARID,
  output logic [7:0]             m_axi_ARLEN,
  output logic [2:0]             m_axi_ARSIZE,
  output logic [1:0]             m_axi_ARBURST,
  output logic [1:0]             m_axi_ARLOCK,
  output logic [3:0]             m_axi_ARCACHE,
  output logic [2:0]             m_axi_ARPROT,
  output logic [3:0]             m_axi_ARQOS,
  output logic [3:0]             m_axi_ARREGION,
  input  logic                   m_axi_RVALID,
  input  logic [DATA_WIDTH-1:0]  m_axi_RDATA,
  input  logic [1:0]             m_axi_RRESP,
  input  logic                   m_axi_RLAST,
  input  logic [ID_WIDTH-1:0]    m_axi_RID,
  output logic                   m_axi_RREADY
);

  // log2 of bytes per beat
  localparam int unsigned BEAT_SHIFT = (DATA_WIDTH == 512) ? 6 : 5;

  eng_state_e            state_q;
  logic [WG_W-1:0]       wg_q;
  logic [WG_W-1:0]       wg_mask_q;
  logic [STRIDE_W-1:0]   stride_q;
  logic [NOPS_W-1:0]     nops_q;
  logic [NOPS_W-1:0]     nops_m1_q;
  logic [BURST_W-1:0]    burst_q;
  logic [ADDR_WIDTH-1:0] init_q;
  logic                  lat_mode_q;
  logic [7:0]            arlen_q;
  logic [NOPS_W-1:0]     ar_cnt_q;
  logic [NOPS_W-1:0]     rlast_cnt_q;
  logic [TIMER_W-1:0]    timer_q;
  logic [ERR_W-1:0]      err_q;
  logic                  arvalid_q;
  logic                  eoe_q;

  logic ar_fire_c;
  logic rlast_c;
  logic rerr_c;
  logic run_c;
  logic unused_sink_c;

  assign ar_fire_c = arvalid_q & m_axi_ARREADY;
  assign rlast_c   = m_axi_RVALID & m_axi_RLAST;
  assign rerr_c    = m_axi_RVALID & (m_axi_RRESP != 2'b00);
  // R beats only count while a run is active past STARTED
  assign run_c     = (state_q != ST_IDLE) && (state_q != ST_STARTED);

  // Read data and ID are sunk; reserved parameter bits are ignored
  assign unused_sink_c = ^{m_axi_RDATA, m_axi_RID,
                           lt_params[LAT_MODE_BIT-1:INIT_LSB+ADDR_WIDTH]};

  hbm_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (state_q == ST_STARTED),
    .advance_i   (ar_fire_c),
    .init_addr_i (init_q),
    .stride_i    (stride_q),
    .mask_i      (ADDR_WIDTH'(wg_mask_q)),
    .addr_o      (m_axi_ARADDR)
  );

  // Engine FSM with its counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wg_q        <= '0;
      wg_mask_q   <= '0;
      stride_q    <= '0;
      nops_q      <= '0;
      nops_m1_q   <= '0;
      burst_q     <= '0;
      init_q      <= '0;
      lat_mode_q  <= 1'b0;
      arlen_q     <= '0;
      ar_cnt_q    <= '0;
      rlast_cnt_q <= '0;
      timer_q     <= '0;
      err_q       <= '0;
      arvalid_q   <= 1'b0;
      eoe_q       <= 1'b0;
    end else begin
      eoe_q <= 1'b0;

      // Saturating error-beat counter; STARTED below overrides with a clear
      if (run_c && rerr_c && (err_q != '1)) begin
        err_q <= err_q + ERR_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            wg_q       <= lt_params[WG_LSB +: WG_W];
            stride_q   <= lt_params[STRIDE_LSB +: STRIDE_W];
            nops_q     <= lt_params[NOPS_LSB +: NOPS_W];
            burst_q    <= lt_params[BURST_LSB +: BURST_W];
            init_q     <= lt_params[INIT_LSB +: ADDR_WIDTH];
            lat_mode_q <= lt_params[LAT_MODE_BIT];
            state_q    <= ST_STARTED;
          end
        end

        ST_STARTED: begin
          wg_mask_q   <= wg_q - WG_W'(1);
          nops_m1_q   <= nops_q - NOPS_W'(1);
          arlen_q     <= 8'((burst_q >> BEAT_SHIFT) - BURST_W'(1));
          ar_cnt_q    <= '0;
          rlast_cnt_q <= '0;
          timer_q     <= '0;
          err_q       <= '0;
          if (nops_q == '0) begin
            state_q <= ST_END;
          end else if (lat_mode_q) begin
            arvalid_q <= 1'b1;
            state_q   <= ST_LAT_ADDR;
          end else begin
            arvalid_q <= 1'b1;
            state_q   <= ST_TH_ADDR;
          end
        end

        ST_TH_ADDR: begin
          if (rlast_c) begin
            rlast_cnt_q <= rlast_cnt_q + NOPS_W'(1);
          end
          if (rlast_cnt_q != nops_q) begin
            timer_q <= timer_q + TIMER_W'(1);
          end
          if (ar_fire_c) begin
            ar_cnt_q <= ar_cnt_q + NOPS_W'(1);
            if (ar_cnt_q == nops_m1_q) begin
              arvalid_q <= 1'b0;
              state_q   <= ST_TH_DATA;
            end
          end
        end

        // Timer stops after the cycle that carried the final RLAST
        ST_TH_DATA: begin
          if (rlast_cnt_q == nops_q) begin
            state_q <= ST_END;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
            if (rlast_c) begin
              rlast_cnt_q <= rlast_cnt_q + NOPS_W'(1);
            end
          end
        end

        ST_LAT_ADDR: begin
          if (ar_fire_c) begin
            arvalid_q <= 1'b0;
            ar_cnt_q  <= ar_cnt_q + NOPS_W'(1);
            state_q   <= ST_LAT_WAIT;
          end
        end

        // Counts from the cycle after AR accept through the RLAST cycle
        ST_LAT_WAIT: begin
          timer_q <= timer_q + TIMER_W'(1);
          if (rlast_c) begin
            rlast_cnt_q <= rlast_cnt_q + NOPS_W'(1);
            if (rlast_cnt_q == nops_m1_q) begin
              state_q <= ST_END;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ST_LAT_ADDR;
            end
          end
        end

        ST_END: begin
          eoe_q   <= 1'b1;
          state_q <= ST_IDLE;
        end

        default: begin
          arvalid_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign end_of_exec    = eoe_q;
  assign lat_timer_sum  = timer_q;
  assign rd_err_cnt     = err_q;
  assign m_axi_ARVALID  = arvalid_q;
  assign m_axi_ARID     = '0;
  assign m_axi_ARLEN    = arlen_q;
  assign m_axi_ARSIZE   = axsize_f(DATA_WIDTH);
  assign m_axi_ARBURST  = AXI_BURST_INCR;
  assign m_axi_ARLOCK   = AXI_LOCK;
  assign m_axi_ARCACHE  = AXI_CACHE;
  assign m_axi_ARPROT   = AXI_PROT;
  assign m_axi_ARQOS    = AXI_QOS;
  assign m_axi_ARREGION = AXI_REGION;
  assign m_axi_RREADY   = 1'b1;

endmodule
